// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data memory sequencer for the pipelined MIPS core.
// Issues lw/sw accesses over a req/ack handshake, stalls the pipeline until the
// access completes, latches load data for MEM/WB and keeps perf counters.
// Optional feature macro: DMEM_TIMEOUT_EN (abort an access after TIMEOUT_CYC
// ACCESS cycles without ack and raise a sticky err_o).
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  acc_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic                access_c;
    logic                stall_c;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                err_q, err_d;
`else
    logic                unused_tmo_c;
    assign unused_tmo_c = ^32'(TIMEOUT_CYC);
`endif

    assign access_c = MemRead_i | MemWrite_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, latched request fields, load data and counters.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        acc_cnt_d   = acc_cnt_q;
        stall_c     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    stall_c = 1'b1;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    // A simultaneous read request is dropped: the write wins.
                    we_d    = MemWrite_i;
                    state_d = ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (mem_ack_i) begin
                    state_d   = ST_DONE;
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
`ifdef DMEM_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_c);
    end

    // Datapath and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign stall_o     = stall_c;
    assign mem_req_o   = (state_q == ST_ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign stall_cnt_o = stall_cnt_q;
    assign acc_cnt_o   = acc_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: reset mid-access, lw, sw with slow ack,
// back-to-back accesses, read/write collision, spurious acks and the
// timeout (or indefinite wait) behaviour depending on DMEM_TIMEOUT_EN.
module tb_dmem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [31:0] stall_cnt_o, acc_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    dmem_access_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(32), .TIMEOUT_CYC(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o), .acc_cnt_o(acc_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational stall_o settle after input changes.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Power-on reset
        cyc(); cyc();
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_we", 64'(mem_we_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_scnt", 64'(stall_cnt_o), 64'd0);
        rst_i = 1'b1;

        // Reset asserted in the middle of an access
        MemRead_i = 1'b1; addr_i = 32'h44; settle();
        chk("mid_idle_stall", 64'(stall_o), 64'd1);
        cyc();
        chk("mid_req", 64'(mem_req_o), 64'd1);
        chk("mid_addr", 64'(mem_addr_o), 64'h44);
        cyc();
        rst_i = 1'b0; MemRead_i = 1'b0;
        cyc();
        chk("mid_rst_req", 64'(mem_req_o), 64'd0);
        chk("mid_rst_stall", 64'(stall_o), 64'd0);
        cyc();
        rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hFEEDFACE;
        cyc();
        mem_ack_i = 1'b0;
        chk("post_rst_req", 64'(mem_req_o), 64'd0);
        chk("post_rst_stall", 64'(stall_o), 64'd0);
        chk("post_rst_rdata", 64'(rdata_o), 64'd0);
        chk("post_rst_scnt", 64'(stall_cnt_o), 64'd0);
        chk("post_rst_acnt", 64'(acc_cnt_o), 64'd0);

        // lw 0x10 acked in the first ACCESS cycle
        MemRead_i = 1'b1; addr_i = 32'h10; settle();
        chk("lw_idle_stall", 64'(stall_o), 64'd1);
        cyc();
        chk("lw_req", 64'(mem_req_o), 64'd1);
        chk("lw_we", 64'(mem_we_o), 64'd0);
        chk("lw_addr", 64'(mem_addr_o), 64'h10);
        chk("lw_acc_stall", 64'(stall_o), 64'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        cyc();
        mem_ack_i = 1'b0; MemRead_i = 1'b0; mem_rdata_i = 32'h0;
        settle();
        chk("lw_done_stall", 64'(stall_o), 64'd0);
        chk("lw_done_req", 64'(mem_req_o), 64'd0);
        chk("lw_rdata", 64'(rdata_o), 64'h12345678);
        chk("lw_acnt", 64'(acc_cnt_o), 64'd1);
        chk("lw_scnt", 64'(stall_cnt_o), 64'd2);
        cyc();
        chk("lw_idle_req", 64'(mem_req_o), 64'd0);

        // sw 0x20 with ack in the 5th ACCESS cycle; pipeline inputs change meanwhile
        MemWrite_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hCAFEF00D;
        cyc();
        addr_i = 32'h99; wdata_i = 32'h55555555; mem_rdata_i = 32'hDEADBEEF;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("sw_req_%0d", i), 64'(mem_req_o), 64'd1);
            chk($sformatf("sw_we_%0d", i), 64'(mem_we_o), 64'd1);
            chk($sformatf("sw_addr_%0d", i), 64'(mem_addr_o), 64'h20);
            chk($sformatf("sw_wdata_%0d", i), 64'(mem_wdata_o), 64'hCAFEF00D);
            if (i == 5) mem_ack_i = 1'b1;
            cyc();
        end
        mem_ack_i = 1'b0; MemWrite_i = 1'b0;
        settle();
        chk("sw_done_stall", 64'(stall_o), 64'd0);
        chk("sw_done_req", 64'(mem_req_o), 64'd0);
        chk("sw_scnt", 64'(stall_cnt_o), 64'd8);
        chk("sw_acnt", 64'(acc_cnt_o), 64'd2);
        chk("sw_rdata_kept", 64'(rdata_o), 64'h12345678);
        cyc();

        // Back-to-back lw 0x30 then sw 0x34
        MemRead_i = 1'b1; addr_i = 32'h30;
        cyc();
        chk("b2b_lw_req", 64'(mem_req_o), 64'd1);
        chk("b2b_lw_we", 64'(mem_we_o), 64'd0);
        chk("b2b_lw_addr", 64'(mem_addr_o), 64'h30);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A50001;
        cyc();
        mem_ack_i = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h34; wdata_i = 32'h11112222;
        settle();
        chk("b2b_done_req", 64'(mem_req_o), 64'd0);
        chk("b2b_done_stall", 64'(stall_o), 64'd0);
        chk("b2b_lw_rdata", 64'(rdata_o), 64'hA5A50001);
        cyc();
        chk("b2b_gap_req", 64'(mem_req_o), 64'd0);
        chk("b2b_gap_stall", 64'(stall_o), 64'd1);
        cyc();
        chk("b2b_sw_req", 64'(mem_req_o), 64'd1);
        chk("b2b_sw_we", 64'(mem_we_o), 64'd1);
        chk("b2b_sw_addr", 64'(mem_addr_o), 64'h34);
        mem_ack_i = 1'b1;
        cyc();
        mem_ack_i = 1'b0; MemWrite_i = 1'b0;
        chk("b2b_acnt", 64'(acc_cnt_o), 64'd4);
        chk("b2b_scnt", 64'(stall_cnt_o), 64'd12);
        chk("b2b_rdata", 64'(rdata_o), 64'hA5A50001);
        cyc();

        // Non-memory instructions and a spurious ack in IDLE
        for (int i = 0; i < 3; i++) begin
            addr_i = 32'(i * 4 + 8);
            mem_ack_i = (i == 1);
            settle();
            chk($sformatf("nomem_stall_%0d", i), 64'(stall_o), 64'd0);
            cyc();
            chk($sformatf("nomem_req_%0d", i), 64'(mem_req_o), 64'd0);
        end
        mem_ack_i = 1'b0;
        chk("spur_acnt", 64'(acc_cnt_o), 64'd4);
        chk("spur_scnt", 64'(stall_cnt_o), 64'd12);

        // MemRead and MemWrite together: the write is issued
        MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h0BADF00D;
        cyc();
        chk("both_req", 64'(mem_req_o), 64'd1);
        chk("both_we", 64'(mem_we_o), 64'd1);
        chk("both_addr", 64'(mem_addr_o), 64'h40);
        chk("both_wdata", 64'(mem_wdata_o), 64'h0BADF00D);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
        cyc();
        mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        chk("both_rdata_kept", 64'(rdata_o), 64'hA5A50001);
        chk("both_acnt", 64'(acc_cnt_o), 64'd5);
        cyc();
        chk("both_scnt", 64'(stall_cnt_o), 64'd14);

`ifdef DMEM_TIMEOUT_EN
        // lw 0x50 never acked: abort after 4 ACCESS cycles
        MemRead_i = 1'b1; addr_i = 32'h50;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo_req_%0d", i), 64'(mem_req_o), 64'd1);
            chk($sformatf("tmo_err_%0d", i), 64'(err_o), 64'd0);
            cyc();
        end
        MemRead_i = 1'b0;
        settle();
        chk("tmo_done_req", 64'(mem_req_o), 64'd0);
        chk("tmo_done_stall", 64'(stall_o), 64'd0);
        chk("tmo_err", 64'(err_o), 64'd1);
        chk("tmo_rdata", 64'(rdata_o), 64'd0);
        chk("tmo_acnt", 64'(acc_cnt_o), 64'd5);
        chk("tmo_scnt", 64'(stall_cnt_o), 64'd19);
        cyc(); cyc();
        chk("tmo_err_sticky", 64'(err_o), 64'd1);
`else
        // lw 0x50 waits 70 ACCESS cycles for its ack; no abort without the timeout
        MemRead_i = 1'b1; addr_i = 32'h50;
        cyc();
        for (int i = 1; i <= 70; i++) begin
            if (i == 1 || i == 70) begin
                chk($sformatf("wait_req_%0d", i), 64'(mem_req_o), 64'd1);
                chk($sformatf("wait_err_%0d", i), 64'(err_o), 64'd0);
            end
            if (i == 70) begin
                mem_ack_i = 1'b1; mem_rdata_i = 32'h600DCAFE;
            end
            cyc();
        end
        mem_ack_i = 1'b0; MemRead_i = 1'b0;
        chk("wait_rdata", 64'(rdata_o), 64'h600DCAFE);
        chk("wait_acnt", 64'(acc_cnt_o), 64'd6);
        chk("wait_scnt", 64'(stall_cnt_o), 64'd85);
        chk("wait_err", 64'(err_o), 64'd0);
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
